uart_rx_packetizer: RTL and testbench

- Serial receive front end for the instruction-load path. Samples the asynchronous UART `rx` line, deframes 8N1 bytes and presents each byte on a four-phase `packet_ready`/`packet_ack` handshake.
- The downstream consumer is the CPU instruction loader. It assembles bytes into 24-bit iRAM words and clears `packet_ack` only after `packet_ready` falls.
- Provides one byte of holding buffer and reports framing and overrun errors.

---
 rtl/uart_rx_packetizer_if.sv | 20 ++
 rtl/uart_rx_packetizer.sv | 149 ++++++++++++++
 tb/tb_uart_rx_packetizer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_packetizer_if.sv
// Byte handshake and status bundle between the UART receiver and the instruction loader.
// The receiver side uses master; the loader side uses slave.
interface uart_rx_packetizer_if;
  logic       packet_ack;
  logic [7:0] uart_packet;
  logic       packet_ready;
  logic       framing_error;
  logic       overrun_error;
  logic       rx_busy;

  modport master (
    input  packet_ack,
    output uart_packet, packet_ready, framing_error, overrun_error, rx_busy
  );

  modport slave (
    output packet_ack,
    input  uart_packet, packet_ready, framing_error, overrun_error, rx_busy
  );
endinterface

// File: rtl/uart_rx_packetizer.sv
// 8N1 UART receiver with a one-byte four-phase holding buffer; ready rises 2 edges after the stop sample.
// The receiver never stalls: a byte completing while the buffer is occupied is dropped and flagged as overrun.
module uart_rx_packetizer #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int CNT_W        = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  uart_rx_packetizer_if.master   pkt
);

  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rstate_t;
  typedef enum logic [1:0] {H_EMPTY, H_WAIT, H_READY} hstate_t;

  logic             rx_m, rx_s;
  rstate_t          r_state, r_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       bit_idx, idx_next;
  logic [7:0]       shift, shift_next;
  logic             byte_done, done_next;
  logic             framing_q, fe_next;
  hstate_t          h_state, h_next;
  logic [7:0]       packet_q;
  logic             load;
  logic             overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      r_state   <= R_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      byte_done <= 1'b0;
      framing_q <= 1'b0;
      h_state   <= H_EMPTY;
      packet_q  <= '0;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      r_state   <= r_next;
      cnt       <= cnt_next;
      bit_idx   <= idx_next;
      shift     <= shift_next;
      byte_done <= done_next;
      framing_q <= fe_next;
      h_state   <= h_next;
      if (load) packet_q <= shift;
    end
  end

  always_comb begin
    r_next     = r_state;
    cnt_next   = cnt;
    idx_next   = bit_idx;
    shift_next = shift;
    done_next  = 1'b0;
    fe_next    = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (!rx_s) begin
          cnt_next = '0;
          r_next   = R_START;
        end
      end
      R_START: begin
        // Mid start bit: a line already back high was only a glitch.
        if (cnt == HALF_CNT) begin
          cnt_next = '0;
          idx_next = '0;
          r_next   = rx_s ? R_IDLE : R_DATA;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      R_DATA: begin
        if (cnt == FULL_CNT) begin
          cnt_next   = '0;
          shift_next = {rx_s, shift[7:1]};
          idx_next   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) r_next = R_STOP;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      R_STOP: begin
        if (cnt == FULL_CNT) begin
          cnt_next = '0;
          if (rx_s) begin
            done_next = 1'b1;
            r_next    = R_IDLE;
          end else begin
            fe_next = 1'b1;
            r_next  = R_BREAK;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      R_BREAK: begin
        if (rx_s) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // New ready is withheld until the loader has released its previous ack.
  always_comb begin
    h_next  = h_state;
    load    = 1'b0;
    overrun = 1'b0;
    case (h_state)
      H_EMPTY: begin
        if (byte_done) begin
          load   = 1'b1;
          h_next = H_WAIT;
        end
      end
      H_WAIT: begin
        if (!pkt.packet_ack) h_next = H_READY;
        if (byte_done) overrun = 1'b1;
      end
      H_READY: begin
        if (pkt.packet_ack) begin
          h_next = H_EMPTY;
          if (byte_done) begin
            load   = 1'b1;
            h_next = H_WAIT;
          end
        end else if (byte_done) begin
          overrun = 1'b1;
        end
      end
      default: h_next = H_EMPTY;
    endcase
  end

  assign pkt.uart_packet   = packet_q;
  assign pkt.packet_ready  = (h_state == H_READY);
  assign pkt.framing_error = framing_q;
  assign pkt.overrun_error = overrun;
  assign pkt.rx_busy       = (r_state != R_IDLE);

endmodule

// File: tb/tb_uart_rx_packetizer.sv
// Directed bench for uart_rx_packetizer at 16 clocks per bit with a one-cycle-lag loader model.
module tb_uart_rx_packetizer;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;

  uart_rx_packetizer_if pk();

  uart_rx_packetizer #(.CLKS_PER_BIT(CPB), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .pkt (pk)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t_start = 0;
  bit ack_en = 1'b1;
  logic ready_neg = 1'b0;
  logic busy_q = 1'b0;
  logic ack_q = 1'b0;
  int rdy_cnt = 0, fe_cnt = 0, ov_cnt = 0, both_cnt = 0, viol_cnt = 0;
  int rdy_rise_cyc = 0, rdy_fall_cyc = 0, ack_rise_cyc = 0;
  int busy_rise_cyc = 0, busy_fall_cyc = 0, fe_cyc = 0, ov_cyc = 0;
  logic [7:0] got [0:63];
  int got_n = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Loader: ack follows ready one cycle late, so it also drops one cycle after ready falls.
  always @(posedge clk) begin
    #1;
    pk.packet_ack = ack_en ? ready_neg : 1'b0;
  end

  always @(negedge clk) begin
    if (pk.packet_ready === 1'b1 && ready_neg === 1'b0) begin
      rdy_cnt++;
      rdy_rise_cyc = cyc;
      if (got_n < 64) got[got_n] = pk.uart_packet;
      got_n++;
      if (pk.packet_ack === 1'b1) viol_cnt++;
    end
    if (pk.packet_ready === 1'b0 && ready_neg === 1'b1) rdy_fall_cyc = cyc;
    if (pk.packet_ack === 1'b1 && ack_q !== 1'b1) ack_rise_cyc = cyc;
    if (pk.rx_busy === 1'b1 && busy_q === 1'b0) busy_rise_cyc = cyc;
    if (pk.rx_busy === 1'b0 && busy_q === 1'b1) busy_fall_cyc = cyc;
    if (pk.framing_error === 1'b1) begin fe_cnt++; fe_cyc = cyc; end
    if (pk.overrun_error === 1'b1) begin ov_cnt++; ov_cyc = cyc; end
    if (pk.framing_error === 1'b1 && pk.overrun_error === 1'b1) both_cnt++;
    ready_neg = pk.packet_ready;
    busy_q    = pk.rx_busy;
    ack_q     = pk.packet_ack;
  end

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_n);
    t_start = cyc;
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    hold(stop_v, stop_n);
    rx = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (pk.packet_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b want 0", pk.packet_ready); end
    vectors++; if (pk.rx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", pk.rx_busy); end
    vectors++; if (pk.uart_packet !== 8'h00) begin miscompares++; $display("FAIL reset_packet got %h want 00", pk.uart_packet); end
    vectors++; if ({pk.framing_error, pk.overrun_error} !== 2'b00) begin miscompares++; $display("FAIL reset_errors got %b want 00", {pk.framing_error, pk.overrun_error}); end
    rst = 1'b0;
    hold(1'b1, 4);
  endtask

  task automatic test_single;
    int r0, n0, f0, o0;
    r0 = rdy_cnt; n0 = got_n; f0 = fe_cnt; o0 = ov_cnt;
    send_frame(8'hA5, 1'b1, CPB);
    hold(1'b1, 8);
    vectors++; if (rdy_cnt - r0 !== 1) begin miscompares++; $display("FAIL single_count got %0d want 1", rdy_cnt - r0); end
    vectors++; if (got[n0] !== 8'hA5) begin miscompares++; $display("FAIL single_value got %h want a5", got[n0]); end
    vectors++; if (rdy_rise_cyc - t_start !== 157) begin miscompares++; $display("FAIL single_latency got %0d want 157", rdy_rise_cyc - t_start); end
    vectors++; if (rdy_fall_cyc - ack_rise_cyc !== 1) begin miscompares++; $display("FAIL single_ack_drop got %0d want 1", rdy_fall_cyc - ack_rise_cyc); end
    vectors++; if (busy_rise_cyc - t_start !== 3) begin miscompares++; $display("FAIL single_busy_rise got %0d want 3", busy_rise_cyc - t_start); end
    vectors++; if (busy_fall_cyc - t_start !== 155) begin miscompares++; $display("FAIL single_busy_fall got %0d want 155", busy_fall_cyc - t_start); end
    vectors++; if ((fe_cnt - f0) + (ov_cnt - o0) !== 0) begin miscompares++; $display("FAIL single_errors got %0d want 0", (fe_cnt - f0) + (ov_cnt - o0)); end
  endtask

  task automatic test_back_to_back;
    int r0, n0, f0, o0;
    logic [7:0] exp [0:2];
    exp[0] = 8'hFF; exp[1] = 8'h00; exp[2] = 8'h00;
    r0 = rdy_cnt; n0 = got_n; f0 = fe_cnt; o0 = ov_cnt;
    for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1, CPB);
    hold(1'b1, 8);
    vectors++; if (rdy_cnt - r0 !== 3) begin miscompares++; $display("FAIL b2b_count got %0d want 3", rdy_cnt - r0); end
    for (int i = 0; i < 3; i++) begin
      vectors++; if (got[n0 + i] !== exp[i]) begin miscompares++; $display("FAIL b2b_value%0d got %h want %h", i, got[n0 + i], exp[i]); end
    end
    vectors++; if ((fe_cnt - f0) + (ov_cnt - o0) !== 0) begin miscompares++; $display("FAIL b2b_errors got %0d want 0", (fe_cnt - f0) + (ov_cnt - o0)); end
    vectors++; if (viol_cnt !== 0) begin miscompares++; $display("FAIL b2b_ready_under_ack got %0d want 0", viol_cnt); end
  endtask

  task automatic test_overrun;
    int r0, o0;
    r0 = rdy_cnt; o0 = ov_cnt;
    ack_en = 1'b0;
    send_frame(8'h11, 1'b1, CPB);
    send_frame(8'h22, 1'b1, CPB);
    hold(1'b1, 4);
    vectors++; if (pk.packet_ready !== 1'b1) begin miscompares++; $display("FAIL ovr_ready got %b want 1", pk.packet_ready); end
    vectors++; if (pk.uart_packet !== 8'h11) begin miscompares++; $display("FAIL ovr_held got %h want 11", pk.uart_packet); end
    vectors++; if (ov_cnt - o0 !== 1) begin miscompares++; $display("FAIL ovr_count got %0d want 1", ov_cnt - o0); end
    vectors++; if (ov_cyc - t_start !== 155) begin miscompares++; $display("FAIL ovr_timing got %0d want 155", ov_cyc - t_start); end
    vectors++; if (rdy_cnt - r0 !== 1) begin miscompares++; $display("FAIL ovr_handshakes got %0d want 1", rdy_cnt - r0); end
    ack_en = 1'b1;
    hold(1'b1, 8);
    vectors++; if (pk.packet_ready !== 1'b0) begin miscompares++; $display("FAIL ovr_release got %b want 0", pk.packet_ready); end
  endtask

  task automatic test_framing;
    int r0, n0, f0;
    r0 = rdy_cnt; f0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 3 * CPB);
    hold(1'b1, CPB);
    vectors++; if (fe_cnt - f0 !== 1) begin miscompares++; $display("FAIL frm_count got %0d want 1", fe_cnt - f0); end
    vectors++; if (fe_cyc - t_start !== 155) begin miscompares++; $display("FAIL frm_timing got %0d want 155", fe_cyc - t_start); end
    vectors++; if (rdy_cnt - r0 !== 0) begin miscompares++; $display("FAIL frm_no_ready got %0d want 0", rdy_cnt - r0); end
    n0 = got_n;
    send_frame(8'h5A, 1'b1, CPB);
    hold(1'b1, 8);
    vectors++; if (got[n0] !== 8'h5A || rdy_cnt - r0 !== 1) begin miscompares++; $display("FAIL frm_recover got %h/%0d want 5a/1", got[n0], rdy_cnt - r0); end
    vectors++; if (fe_cnt - f0 !== 1) begin miscompares++; $display("FAIL frm_single_pulse got %0d want 1", fe_cnt - f0); end
  endtask

  task automatic test_glitch;
    int r0, f0, o0, tg;
    r0 = rdy_cnt; f0 = fe_cnt; o0 = ov_cnt;
    tg = cyc;
    hold(1'b0, 4);
    hold(1'b1, 2 * CPB);
    vectors++; if (busy_rise_cyc - tg !== 3) begin miscompares++; $display("FAIL glitch_busy_rise got %0d want 3", busy_rise_cyc - tg); end
    vectors++; if (busy_fall_cyc - tg !== 11) begin miscompares++; $display("FAIL glitch_busy_fall got %0d want 11", busy_fall_cyc - tg); end
    vectors++; if ((rdy_cnt - r0) + (fe_cnt - f0) + (ov_cnt - o0) !== 0) begin miscompares++; $display("FAIL glitch_quiet got %0d want 0", (rdy_cnt - r0) + (fe_cnt - f0) + (ov_cnt - o0)); end
  endtask

  task automatic test_reset_mid;
    int r0, n0, f0, o0;
    logic [7:0] b;
    b = 8'h81;
    r0 = rdy_cnt; f0 = fe_cnt; o0 = ov_cnt;
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(b[i], CPB);
    hold(b[4], 5);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if ({pk.packet_ready, pk.rx_busy} !== 2'b00) begin miscompares++; $display("FAIL rstmid_ready_busy got %b want 00", {pk.packet_ready, pk.rx_busy}); end
    vectors++; if (pk.uart_packet !== 8'h00) begin miscompares++; $display("FAIL rstmid_packet got %h want 00", pk.uart_packet); end
    rst = 1'b0;
    hold(1'b1, 2 * CPB);
    n0 = got_n;
    send_frame(8'h7E, 1'b1, CPB);
    hold(1'b1, 8);
    vectors++; if (got[n0] !== 8'h7E || rdy_cnt - r0 !== 1) begin miscompares++; $display("FAIL rstmid_next got %h/%0d want 7e/1", got[n0], rdy_cnt - r0); end
    vectors++; if ((fe_cnt - f0) + (ov_cnt - o0) !== 0) begin miscompares++; $display("FAIL rstmid_errors got %0d want 0", (fe_cnt - f0) + (ov_cnt - o0)); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_overrun;
    test_framing;
    test_glitch;
    test_reset_mid;
    vectors++; if (both_cnt !== 0) begin miscompares++; $display("FAIL errors_same_cycle got %0d want 0", both_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
